// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, redirect handling,
// and an IF/ID output slot backed by a one-entry skid buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_fire;
    logic        w_keep;
    logic        w_drain;

    assign w_redirect = branch_taken | jump;
    assign w_target   = (jump ? jump_target : branch_target) & ~32'd3;
    assign w_fire     = imem_req & imem_gnt;
    // A response is kept only in WAIT and only if no redirect kills it this cycle.
    assign w_keep     = (r_state == StWait) & imem_rvalid & ~w_redirect;
    assign w_drain    = ~r_if_valid | ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_fire) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    w_state_d = StIdle;
                end else if (w_redirect) begin
                    w_state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (r_state == StIdle && !r_skid_valid && !w_redirect && !rst) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC & ~32'd3;
            r_req_pc     <= RESET_PC & ~32'd3;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= NOP;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'd0;
            r_if_instr   <= NOP;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_fire) begin
                r_req_pc <= r_pc;
            end

            if (w_redirect) begin
                r_if_valid   <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_drain) begin
                // Skid holds the older instruction, so it always drains first.
                if (r_skid_valid) begin
                    r_if_valid   <= 1'b1;
                    r_if_pc      <= r_skid_pc;
                    r_if_instr   <= r_skid_instr;
                    r_skid_valid <= w_keep;
                    if (w_keep) begin
                        r_skid_pc    <= r_req_pc;
                        r_skid_instr <= imem_rdata;
                    end
                end else if (w_keep) begin
                    r_if_valid <= 1'b1;
                    r_if_pc    <= r_req_pc;
                    r_if_instr <= imem_rdata;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end else if (w_keep) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_req_pc;
                r_skid_instr <= imem_rdata;
            end
        end
    end

    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_if_instr;
    assign if_pc_plus4 = r_if_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed groups push expected IF/ID
// transfers; a monitor pops and compares each instruction handed to decode.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_pc_plus4   (if_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Memory: data word is addr ^ 0xA5A5_0000, rvalid arrives mem_lat cycles after grant.
    int          mem_lat = 1;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'd0;

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (m_pend) begin
            if (m_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= m_addr ^ 32'hA5A5_0000;
                m_pend      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (imem_req && imem_gnt) begin
            if (mem_lat == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= imem_addr ^ 32'hA5A5_0000;
            end else begin
                m_pend <= 1'b1;
                m_cnt  <= mem_lat - 1;
                m_addr <= imem_addr;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] p4);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.plus4 = p4;
        q.push_back(e);
    endtask

    // Monitor: every instruction accepted by decode must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && if_valid && !stall) begin
                if (q.size() == 0) begin
                    check("unexpected_if", if_pc, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                    check("if_pc_plus4", if_pc_plus4, e.plus4);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_pc"}, if_pc, 32'd0);
        check({tag, "_instr"}, if_instr, 32'h0000_0013);
        check({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    // Returns one cycle into C0, the first cycle after reset release.
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        imem_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in_reset");
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (q.size() != 0 && n < 60);
        check({name, "_drain_left"}, q.size(), 32'd0);
        q.delete();
    endtask

    task automatic wait_fire(input logic [31:0] a, input string name);
        int   n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            hit = imem_req && imem_gnt && (imem_addr == a);
        end
        check({name, "_fire_seen"}, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp_req;
        logic [4:0] exp_vld;

        // Sequential fetch with minimum latency and one-per-two-cycle throughput.
        exp_req = 5'b10101;
        exp_vld = 5'b10100;
        mem_lat = 1;
        do_reset();
        push(32'h0, 32'hA5A5_0000, 32'h4);
        push(32'h4, 32'hA5A5_0004, 32'h8);
        push(32'h8, 32'hA5A5_0008, 32'hC);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("seq_req", {31'd0, imem_req}, {31'd0, exp_req[c]});
            check("seq_valid", {31'd0, if_valid}, {31'd0, exp_vld[c]});
            if (exp_req[c]) check("seq_addr", imem_addr, 32'(c * 2));
        end
        wait_drain("seq");

        // Branch while WAIT at 0x8 (unaligned target is masked); 0x8 response dropped.
        mem_lat = 2;
        do_reset();
        push(32'h0, 32'hA5A5_0000, 32'h4);
        push(32'h4, 32'hA5A5_0004, 32'h8);
        push(32'h100, 32'hA5A5_0100, 32'h104);
        wait_fire(32'h8, "br");
        step();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0103;
        @(negedge clk);
        check("br_req_suppressed", {31'd0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        check("br_drop_req", {31'd0, imem_req}, 32'd0);
        check("br_drop_valid", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        check("br_new_req", {31'd0, imem_req}, 32'd1);
        check("br_new_addr", imem_addr, 32'h100);
        wait_drain("br");

        // Jump and branch together, coinciding with rvalid: jump wins, response discarded.
        mem_lat = 1;
        do_reset();
        push(32'h200, 32'hA5A5_0200, 32'h204);
        step();
        jump = 1'b1;
        jump_target = 32'h200;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        @(negedge clk);
        check("jmp_req_suppressed", {31'd0, imem_req}, 32'd0);
        step();
        jump = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("jmp_req", {31'd0, imem_req}, 32'd1);
        check("jmp_addr", imem_addr, 32'h200);
        wait_drain("jmp");

        // Five-cycle stall: slot held, response lands in skid, requests stop.
        mem_lat = 1;
        do_reset();
        push(32'h0, 32'hA5A5_0000, 32'h4);
        push(32'h4, 32'hA5A5_0004, 32'h8);
        push(32'h8, 32'hA5A5_0008, 32'hC);
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h0);
            check("stall_instr", if_instr, 32'hA5A5_0000);
            if (k >= 2) check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        check("rel_no_req", {31'd0, imem_req}, 32'd0);
        check("rel_pc", if_pc, 32'h0);
        @(negedge clk);
        check("skid_valid", {31'd0, if_valid}, 32'd1);
        check("skid_pc", if_pc, 32'h4);
        check("skid_req", {31'd0, imem_req}, 32'd1);
        check("skid_addr", imem_addr, 32'h8);
        wait_drain("stall");

        // Wrap at the top of the address space.
        mem_lat = 1;
        do_reset();
        push(32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0);
        push(32'h0, 32'hA5A5_0000, 32'h4);
        step();
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        @(negedge clk);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        check("wrap_req", {31'd0, imem_req}, 32'd1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_plus4", if_pc_plus4, 32'h0);
        wait_drain("wrap");

        // Reset during WAIT with a valid slot; stale rvalid afterwards is ignored.
        mem_lat = 3;
        do_reset();
        push(32'h0, 32'hA5A5_0000, 32'h4);
        stall = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        check("pre_rst_addr", imem_addr, 32'h4);
        step();
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        step();
        rst = 1'b0;
        imem_gnt = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("stale_valid", {31'd0, if_valid}, 32'd0);
        check("stable_addr", imem_addr, 32'h0);
        step();
        mem_lat = 1;
        imem_gnt = 1'b1;
        @(negedge clk);
        check("stale_ignored", {31'd0, if_valid}, 32'd0);
        wait_drain("rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: stall  input  1  decode not ready; hold the IF/ID output.
REQ-005 Port: branch_taken  input  1  taken-branch redirect from the branch unit in EX.
REQ-006 Port: branch_target  input  32  branch destination.
REQ-007 Port: jump  input  1  JAL/JALR redirect from EX.
REQ-008 Port: jump_target  input  32  jump destination.
REQ-009 Port: imem_req  output  1  instruction memory request valid.
REQ-010 Port: imem_addr  output  32  request word address, bits[1:0] always 0.
REQ-011 Port: imem_gnt  input  1  request accepted this cycle.
REQ-012 Port: imem_rvalid  input  1  read data valid.
REQ-013 Port: imem_rdata  input  32  fetched instruction.
REQ-014 Port: if_valid  output  1  IF/ID slot holds a valid instruction.
REQ-015 Port: if_pc  output  32  PC of the IF/ID instruction.
REQ-016 Port: if_instr  output  32  IF/ID instruction.
REQ-017 Port: if_pc_plus4  output  32  if_pc + 4, modulo 2^32.

Function
REQ-018 The unit SHALL allow at most one outstanding request (granted, no rvalid yet).
REQ-019 The FSM SHALL have states IDLE (no outstanding), WAIT (outstanding, keep response), DROP (outstanding, discard response).
REQ-020 Request condition: IDLE, skid empty, no redirect this cycle -> imem_req=1, imem_addr=pc.
REQ-021 While imem_req=1 and imem_gnt=0, imem_addr SHALL stay stable unless a redirect occurs.
REQ-022 On imem_req & imem_gnt the FSM SHALL go IDLE->WAIT and pc SHALL become pc+4, wrapping at 2^32.
REQ-023 redirect = branch_taken | jump; target = jump ? jump_target : branch_target, with bits[1:0] forced to 0.
REQ-024 Redirect SHALL load pc with target next cycle, clear if_valid and the skid, and suppress imem_req in the redirect cycle.
REQ-025 Redirect in WAIT, or on the same cycle as a grant, SHALL enter DROP; the response arriving in DROP SHALL be discarded, then the FSM returns to IDLE.
REQ-026 Redirect on the same cycle as imem_rvalid SHALL discard that response.
REQ-027 A kept response (WAIT & rvalid) SHALL load the IF/ID registers if !if_valid | !stall, otherwise the one-entry skid; the FSM then goes to IDLE.
REQ-028 When if_valid & stall, if_valid/if_pc/if_instr SHALL hold unchanged.
REQ-029 When the IF/ID slot drains (!stall) and the skid is full, the skid SHALL move to IF/ID that cycle, before any newer response.
REQ-030 When the slot drains with no new data, if_valid SHALL go 0.
REQ-031 Minimum latency: grant in cycle N, rvalid in N+1 -> if_valid=1 in N+2; sustained throughput is one instruction per 2 cycles.

Reset
REQ-032 While rst=1: pc=RESET_PC, FSM=IDLE, skid empty, imem_req=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
REQ-033 Reset asserted mid-request SHALL abandon the outstanding access; any later rvalid in IDLE SHALL be ignored.
REQ-034 The first cycle after rst deasserts SHALL drive imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-035 Sequential fetch, gnt=1, 1-cycle rvalid, stall=0 -> if_pc 0x0,0x4,0x8 and if_instr equal to memory contents.
REQ-036 branch_taken=1, target 0x100, while WAIT at 0x8 -> 0x8 response dropped, next imem_addr=0x100, next if_pc=0x100.
REQ-037 jump=1 (jump_target 0x200) and branch_taken=1 (branch_target 0x300) together -> fetch at 0x200.
REQ-038 stall=1 for 5 cycles with a response arriving -> IF/ID held, skid filled, no new imem_req; after release, skid instruction appears next cycle in order.
REQ-039 PC=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000, if_pc_plus4=0x0.
REQ-040 rst pulsed while WAIT -> outputs at reset values immediately; stale rvalid ignored; first request after release at RESET_PC.
